vga_sync_monitor: RTL and testbench
===================================

Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator: consumes the hsync_n/vsync_n pair (generated internally or looped back from the connector) and recovers pixel/line position.
- Checks line and frame lengths against 640x480@60 timing, runs a lock state machine and reports errors.
- Used as an on-chip checker for the Pong VGA controller and as a front end for any future capture path.

Parameters:
- H_TOTAL, 800, pixels per line
- H_SYNC, 96, hsync low width
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, active pixels per line
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vsync low lines
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, active lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to lock
- CW, 13, width of the internal counters and the x/y outputs

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel-rate enable; sync inputs are sampled only when 1
- hsync_n  in  1  horizontal sync, active low, synchronous to clk
- vsync_n  in  1  vertical sync, active low, synchronous to clk
- x  out  CW  active-area column, 0..H_ACTIVE-1; 0 when not active
- y  out  CW  active-area row, 0..V_ACTIVE-1; 0 when not active
- active  out  1  locked and inside the active window
- line_start  out  1  one-clk pulse on each qualified hsync falling edge
- frame_start  out  1  one-clk pulse on the line edge that restarts vcount
- locked  out  1  lock FSM is in LOCKED
- line_err  out  1  one-clk pulse: line length != H_TOTAL
- frame_err  out  1  one-clk pulse: frame length != V_TOTAL
- err_count  out  8  saturating count of error cycles

Behaviour:
- Reset values: all outputs 0; hcount = vcount = 0; previous-sync registers = 1; vs_pend = 0; good_cnt = 0; state = SEARCH.
- Outputs are registered: valid 1 clk after the pix_en sample that causes them.
- Sampling and edge detection:
  - All sampling is qualified by pix_en. With pix_en = 0, nothing advances and no pulse fires.
  - A falling edge is prev = 1 and now = 0.
- vsync handling:
  - A vsync_n falling edge sets vs_pend.
  - It is consumed at the next hsync falling edge, or at the same edge if both fall in the same sample.
- Horizontal counting:
  - On an hsync edge: hcount <- 0 and line_start pulses. Otherwise hcount increments, saturating at 2^CW-1.
  - Line check: on an hsync edge with state != SEARCH, if hcount != H_TOTAL-1, line_err pulses.
- Vertical counting (on an hsync edge):
  - If vs_pend: vcount <- 0, clear vs_pend, frame_start pulses.
  - Otherwise vcount increments, saturating.
- Frame check: at frame_start with state != SEARCH, if vcount != V_TOTAL-1, frame_err pulses.
- Active window:
  - Horizontal: H_SYNC+H_BP <= hcount < H_SYNC+H_BP+H_ACTIVE.
  - Vertical: V_SYNC+V_BP <= vcount < V_SYNC+V_BP+V_ACTIVE.
  - x = hcount-(H_SYNC+H_BP); y = vcount-(V_SYNC+V_BP).
  - active, x and y are gated by locked.
- Lock FSM:
  - SEARCH -> ALIGN at the first frame_start; good_cnt = 0.
  - ALIGN: at each frame_start, if there was no line_err or frame_err since the previous frame_start, good_cnt++. Otherwise good_cnt = 0.
  - ALIGN -> LOCKED when good_cnt reaches LOCK_FRAMES.
  - LOCKED: any line_err or frame_err -> ALIGN with good_cnt = 0. locked falls in the same registered update as the error pulse.
- err_count: +1 on any cycle with line_err or frame_err, including when both fire together; saturates at 255. Cleared only by rst.
- Reset mid-frame: everything returns to reset values. The first partial line and frame after reset never flag errors, because checks are disabled in SEARCH.
- Arithmetic: unsigned, CW bits; comparisons use the full counter width.

Decomposition:
- Package vga_timing_pkg: the H_/V_ timing constants (shared with the generator) and the lock-state encoding (SEARCH, ALIGN, LOCKED).
- One sub-module, vga_sync_edge: registered falling-edge detector with pix_en qualification and reset to 1, instantiated twice.

Test Plan:
- Nominal 640x480, pix_en = 1 continuously, 4 frames -> frame_start every 420000 clk; locked rises at the 3rd frame_start; first active has x=0, y=0 at hcount=144, vcount=35; last active pixel x=639, y=479.
- While locked, one line of 799 pixels -> single line_err pulse; locked = 0; err_count = 1; locked returns after 2 further clean frames.
- While locked, one frame of 524 lines -> frame_err pulse at its frame_start; locked drops; err_count increments by 1.
- Assert rst mid-line at vcount = 200 -> all outputs 0 next clk; no line_err/frame_err on the following partial line or frame; lock after 3 frame_starts.
- Drop pix_en for 100 clk at x = 300 -> x holds 300; no line_start; line length check still passes at 800 counted samples.
- hsync_n and vsync_n falling in the same sample -> frame_start and line_start both pulse that cycle; vcount = 0, hcount = 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : 640x480@60 timing constants shared with the VGA generator,
//                plus the lock-state encoding of the sync monitor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int c_h_total     = 800;
  localparam int c_h_sync      = 96;
  localparam int c_h_bp        = 48;
  localparam int c_h_active    = 640;
  localparam int c_v_total     = 525;
  localparam int c_v_sync      = 2;
  localparam int c_v_bp        = 33;
  localparam int c_v_active    = 480;
  localparam int c_lock_frames = 2;
  localparam int c_cw          = 13;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_t;

endpackage

`default_nettype wire

// File: rtl/vga_sync_edge.sv
// ============================================================================
//  Module      : vga_sync_edge
//  Description : Falling-edge detector for an active-low sync line, sampled
//                only on pixel-enable cycles; history register resets to 1.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_pix_en,
  input  logic i_sync_n,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b1;
    end else if (i_pix_en) begin
      r_prev <= i_sync_n;
    end
  end

  assign o_fall = i_pix_en & r_prev & ~i_sync_n;

endmodule

`default_nettype wire

// File: rtl/vga_sync_monitor.sv
// ============================================================================
//  Module      : vga_sync_monitor
//  Description : Recovers pixel/line position from hsync_n/vsync_n, checks
//                line and frame lengths and tracks lock to the nominal timing.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_sync_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = c_h_total,
  parameter int H_SYNC      = c_h_sync,
  parameter int H_BP        = c_h_bp,
  parameter int H_ACTIVE    = c_h_active,
  parameter int V_TOTAL     = c_v_total,
  parameter int V_SYNC      = c_v_sync,
  parameter int V_BP        = c_v_bp,
  parameter int V_ACTIVE    = c_v_active,
  parameter int LOCK_FRAMES = c_lock_frames,
  parameter int CW          = c_cw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          hsync_n,
  input  logic          vsync_n,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic          locked,
  output logic          line_err,
  output logic          frame_err,
  output logic [7:0]    err_count
);

  localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};
  localparam logic [CW-1:0] c_cnt_one = CW'(1);
  localparam logic [CW-1:0] c_h_last  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] c_v_last  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] c_h_start = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] c_h_end   = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] c_v_start = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] c_v_end   = CW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [7:0]    c_lock_n  = 8'(LOCK_FRAMES);

  logic          w_hs_fall;
  logic          w_vs_fall;
  logic          w_fs;
  logic          w_chk;
  logic          w_line_err;
  logic          w_frame_err;
  logic          w_any_err;
  logic          w_h_act;
  logic          w_v_act;
  logic [CW-1:0] w_hcount_nxt;
  logic [CW-1:0] w_vcount_nxt;
  logic [7:0]    w_good_inc;

  logic [CW-1:0] r_hcount;
  logic [CW-1:0] r_vcount;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_act;
  logic          r_vs_pend;
  logic          r_err_seen;
  logic [7:0]    r_good_cnt;
  lock_state_t   r_state;

  vga_sync_edge u_hs_edge (
    .clk      (clk),
    .rst      (rst),
    .i_pix_en (pix_en),
    .i_sync_n (hsync_n),
    .o_fall   (w_hs_fall)
  );

  vga_sync_edge u_vs_edge (
    .clk      (clk),
    .rst      (rst),
    .i_pix_en (pix_en),
    .i_sync_n (vsync_n),
    .o_fall   (w_vs_fall)
  );

  // A pending vsync (or one falling in this very sample) restarts the frame
  // on the line edge.
  assign w_fs        = w_hs_fall & (r_vs_pend | w_vs_fall);
  assign w_chk       = (r_state != ST_SEARCH);
  assign w_line_err  = w_hs_fall & w_chk & (r_hcount != c_h_last);
  assign w_frame_err = w_fs & w_chk & (r_vcount != c_v_last);
  assign w_any_err   = w_line_err | w_frame_err;
  assign w_good_inc  = r_good_cnt + 8'd1;

  always_comb begin
    w_hcount_nxt = r_hcount;
    w_vcount_nxt = r_vcount;
    if (w_hs_fall) begin
      w_hcount_nxt = '0;
      if (w_fs) begin
        w_vcount_nxt = '0;
      end else if (r_vcount != c_cnt_max) begin
        w_vcount_nxt = r_vcount + c_cnt_one;
      end
    end else if (pix_en && (r_hcount != c_cnt_max)) begin
      w_hcount_nxt = r_hcount + c_cnt_one;
    end
  end

  assign w_h_act = (w_hcount_nxt >= c_h_start) && (w_hcount_nxt < c_h_end);
  assign w_v_act = (w_vcount_nxt >= c_v_start) && (w_vcount_nxt < c_v_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcount    <= '0;
      r_vcount    <= '0;
      r_vs_pend   <= 1'b0;
      r_act       <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      r_hcount    <= w_hcount_nxt;
      r_vcount    <= w_vcount_nxt;
      line_start  <= w_hs_fall;
      frame_start <= w_fs;
      line_err    <= w_line_err;
      frame_err   <= w_frame_err;
      if (w_fs) begin
        r_vs_pend <= 1'b0;
      end else if (w_vs_fall) begin
        r_vs_pend <= 1'b1;
      end
      r_act <= w_h_act & w_v_act;
      r_x   <= (w_h_act & w_v_act) ? (w_hcount_nxt - c_h_start) : '0;
      r_y   <= (w_h_act & w_v_act) ? (w_vcount_nxt - c_v_start) : '0;
      if (w_any_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_SEARCH;
      r_good_cnt <= 8'd0;
      r_err_seen <= 1'b0;
      locked     <= 1'b0;
    end else begin
      // Error history covers one frame_start-to-frame_start interval.
      if (w_fs) begin
        r_err_seen <= 1'b0;
      end else if (w_any_err) begin
        r_err_seen <= 1'b1;
      end
      case (r_state)
        ST_SEARCH: begin
          if (w_fs) begin
            r_state    <= ST_ALIGN;
            r_good_cnt <= 8'd0;
          end
        end
        ST_ALIGN: begin
          if (w_fs) begin
            if (r_err_seen || w_any_err) begin
              r_good_cnt <= 8'd0;
            end else begin
              r_good_cnt <= w_good_inc;
              if (w_good_inc >= c_lock_n) begin
                r_state <= ST_LOCKED;
                locked  <= 1'b1;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (w_any_err) begin
            r_state    <= ST_ALIGN;
            r_good_cnt <= 8'd0;
            locked     <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_SEARCH;
          r_good_cnt <= 8'd0;
          locked     <= 1'b0;
        end
      endcase
    end
  end

  assign active = r_act & locked;
  assign x      = locked ? r_x : '0;
  assign y      = locked ? r_y : '0;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
// ============================================================================
//  Module      : tb_vga_sync_monitor
//  Description : Directed bench for vga_sync_monitor on a reduced 20x12 raster
//                driven by a behavioural sync generator.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_sync_monitor;

  localparam int H_TOTAL  = 20;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 2;
  localparam int H_ACTIVE = 12;
  localparam int V_TOTAL  = 12;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int V_ACTIVE = 6;
  localparam int LOCK_N   = 2;
  localparam int CW       = 13;
  localparam int XOFF     = H_SYNC + H_BP;
  localparam int YOFF     = V_SYNC + V_BP;
  localparam int NROWS    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_en;
  logic          hsync_n;
  logic          vsync_n;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          active;
  logic          line_start;
  logic          frame_start;
  logic          locked;
  logic          line_err;
  logic          frame_err;
  logic [7:0]    err_count;

  vga_sync_monitor #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE),
    .LOCK_FRAMES(LOCK_N), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .x(x), .y(y), .active(active), .line_start(line_start),
    .frame_start(frame_start), .locked(locked), .line_err(line_err),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lines;
    int bad_line;
    int bad_len;
    bit vs_early;
    int ls;
    int le;
    int fe;
    bit lk_fs;
    bit lk_end;
    int ec;
    int act;
  } row_t;

  row_t tbl [NROWS];

  int n_checks = 0;
  int n_fail   = 0;

  // generator state and per-interval tallies
  int gen_h, gen_v, ph, pv;
  int fr_lines, bad_line, bad_len;
  bit vs_early;
  int n_ls, n_fs, n_le, n_fe, n_act, n_xy_bad;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    n_ls = 0; n_fs = 0; n_le = 0; n_fe = 0; n_act = 0; n_xy_bad = 0;
  endtask

  task automatic cyc(input bit en);
    int cur_len;
    pix_en  = en;
    hsync_n = (gen_h >= H_SYNC);
    vsync_n = !((gen_v < V_SYNC) ||
                (vs_early && (gen_v == fr_lines - 1) && (gen_h >= H_TOTAL - 5)));
    if (en) begin
      ph = gen_h;
      pv = gen_v;
    end
    @(posedge clk);
    #1;
    if (line_start)  n_ls++;
    if (frame_start) n_fs++;
    if (line_err)    n_le++;
    if (frame_err)   n_fe++;
    if (active) begin
      n_act++;
      if ((int'(x) != ph - XOFF) || (int'(y) != pv - YOFF)) n_xy_bad++;
    end else if ((x != '0) || (y != '0)) begin
      n_xy_bad++;
    end
    if (en) begin
      cur_len = (gen_v == bad_line) ? bad_len : H_TOTAL;
      gen_h++;
      if (gen_h >= cur_len) begin
        gen_h = 0;
        gen_v++;
        if (gen_v >= fr_lines) gen_v = 0;
      end
    end
  endtask

  initial begin
    bit got;
    int fs_cnt;
    // lines, bad_line, bad_len, vs_early | line_starts, line_errs, frame_errs,
    // locked after frame_start, locked at frame end, err_count, active samples
    tbl[0]  = '{12, -1,  0, 1'b0, 12, 0, 0, 1'b0, 1'b0, 0,  0};
    tbl[1]  = '{12, -1,  0, 1'b0, 12, 0, 0, 1'b0, 1'b0, 0,  0};
    tbl[2]  = '{12, -1,  0, 1'b0, 12, 0, 0, 1'b1, 1'b1, 0, 72};
    tbl[3]  = '{12, -1,  0, 1'b0, 12, 0, 0, 1'b1, 1'b1, 0, 72};
    tbl[4]  = '{12,  3, 19, 1'b0, 12, 1, 0, 1'b1, 1'b0, 1,  0};
    tbl[5]  = '{12, -1,  0, 1'b0, 12, 0, 0, 1'b0, 1'b0, 1,  0};
    tbl[6]  = '{12, -1,  0, 1'b0, 12, 0, 0, 1'b0, 1'b0, 1,  0};
    tbl[7]  = '{12, -1,  0, 1'b0, 12, 0, 0, 1'b1, 1'b1, 1, 72};
    tbl[8]  = '{11, -1,  0, 1'b0, 11, 0, 0, 1'b1, 1'b1, 1, 72};
    tbl[9]  = '{12, -1,  0, 1'b0, 12, 0, 1, 1'b0, 1'b0, 2,  0};
    tbl[10] = '{12, -1,  0, 1'b0, 12, 0, 0, 1'b0, 1'b0, 2,  0};
    tbl[11] = '{12, -1,  0, 1'b0, 12, 0, 0, 1'b1, 1'b1, 2, 72};
    tbl[12] = '{11, 10, 21, 1'b0, 11, 0, 0, 1'b1, 1'b1, 2, 72};
    tbl[13] = '{12, -1,  0, 1'b0, 12, 1, 1, 1'b0, 1'b0, 3,  0};
    tbl[14] = '{12, -1,  0, 1'b1, 12, 0, 0, 1'b0, 1'b0, 3,  0};
    tbl[15] = '{12, -1,  0, 1'b0, 12, 0, 0, 1'b1, 1'b1, 3, 72};

    rst = 1'b1; pix_en = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1;
    gen_h = 0; gen_v = 0; ph = 0; pv = 0;
    fr_lines = V_TOTAL; bad_line = -1; bad_len = 0; vs_early = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({x, y, active, line_start, frame_start, locked,
                               line_err, frame_err, err_count}), 0);
    rst = 1'b0;

    for (int i = 0; i < NROWS; i++) begin
      fr_lines = tbl[i].lines;
      bad_line = tbl[i].bad_line;
      bad_len  = tbl[i].bad_len;
      vs_early = tbl[i].vs_early;
      clr();
      cyc(1'b1);
      chk($sformatf("row%0d_fs_pulse", i), int'(frame_start & line_start), 1);
      chk($sformatf("row%0d_locked_at_fs", i), int'(locked), int'(tbl[i].lk_fs));
      while (!((gen_h == 0) && (gen_v == 0))) cyc(1'b1);
      chk($sformatf("row%0d_line_starts", i), n_ls, tbl[i].ls);
      chk($sformatf("row%0d_frame_starts", i), n_fs, 1);
      chk($sformatf("row%0d_line_errs", i), n_le, tbl[i].le);
      chk($sformatf("row%0d_frame_errs", i), n_fe, tbl[i].fe);
      chk($sformatf("row%0d_locked_end", i), int'(locked), int'(tbl[i].lk_end));
      chk($sformatf("row%0d_err_count", i), int'(err_count), tbl[i].ec);
      chk($sformatf("row%0d_active_samples", i), n_act, tbl[i].act);
      chk($sformatf("row%0d_xy_bad", i), n_xy_bad, 0);
    end

    // pix_en dropped mid-line while locked: position must freeze
    clr();
    while (!((gen_v == 5) && (gen_h == 11))) cyc(1'b1);
    cyc(1'b1);
    chk("stall_x_before", int'(x), 6);
    chk("stall_y_before", int'(y), 1);
    clr();
    repeat (100) cyc(1'b0);
    chk("stall_x_hold", int'(x), 6);
    chk("stall_y_hold", int'(y), 1);
    chk("stall_active_hold", int'(active), 1);
    chk("stall_no_line_start", n_ls, 0);
    chk("stall_xy_bad", n_xy_bad, 0);
    clr();
    do cyc(1'b1); while (!((gen_h == 0) && (gen_v == 0)));
    chk("stall_line_errs", n_le, 0);
    chk("stall_line_starts", n_ls, 6);
    chk("stall_still_locked", int'(locked), 1);

    // reset in the middle of a line
    while (!((gen_v == 5) && (gen_h == 10))) cyc(1'b1);
    rst = 1'b1;
    cyc(1'b1);
    rst = 1'b0;
    chk("midreset_outputs", int'({x, y, active, line_start, frame_start, locked,
                                  line_err, frame_err, err_count}), 0);
    clr();
    got = 1'b0;
    for (int i = 0; (i < 1200) && !got; i++) begin
      cyc(1'b1);
      if (locked) got = 1'b1;
    end
    fs_cnt = n_fs;
    chk("relock_reached", int'(got), 1);
    chk("relock_frame_starts", fs_cnt, 3);
    chk("relock_line_errs", n_le, 0);
    chk("relock_frame_errs", n_fe, 0);
    chk("relock_both_edges", int'(frame_start & line_start), 1);
    chk("relock_err_count", int'(err_count), 0);

    // rapid hsync toggling: one line error per fall, counter saturates
    n_le = 0;
    for (int i = 0; i < 300; i++) begin
      pix_en = 1'b1; hsync_n = ((i % 2) == 0); vsync_n = 1'b1;
      @(posedge clk);
      #1;
      if (line_err) n_le++;
    end
    chk("burst_line_errs", n_le, 150);
    chk("burst_err_count", int'(err_count), 150);
    chk("burst_unlocked", int'(locked), 0);
    for (int i = 0; i < 300; i++) begin
      pix_en = 1'b1; hsync_n = ((i % 2) == 0); vsync_n = 1'b1;
      @(posedge clk);
      #1;
      if (line_err) n_le++;
    end
    chk("sat_line_errs", n_le, 300);
    chk("sat_err_count", int'(err_count), 255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
